mips_muldiv_unit: RTL and testbench

- Iterative multiply/divide unit with HI/LO registers for the MIPS pipeline.
- Sits in EXECUTE beside the single-cycle ALU and adds MULT/MULTU/DIV/DIVU/MTHI/MTLO support; MFHI/MFLO read o_hi/o_lo directly.
- o_busy drives the hazard stall path; i_flush lets branch/jump flush logic abort an in-flight operation.

---
 rtl/mips_muldiv_if.sv | 32 +++
 rtl/mips_muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_if.sv
// Port bundle for the HI/LO multiply/divide unit. The EXECUTE stage owns the
// master side and the muldiv unit owns the slave side.
interface mips_muldiv_if #(
  parameter int LENGTH = 32
);
  // Handshake: i_start is accepted on a rising clock edge only while o_busy=0
  // and i_flush=0. o_busy stays high until the result is written. o_done is
  // high for exactly one cycle, and HI/LO are valid in that same cycle.
  logic              i_start;
  logic [1:0]        i_op;
  logic [LENGTH-1:0] i_a;
  logic [LENGTH-1:0] i_b;
  logic              i_mthi;
  logic              i_mtlo;
  logic [LENGTH-1:0] i_wdata;
  logic              i_flush;
  logic [LENGTH-1:0] o_hi;
  logic [LENGTH-1:0] o_lo;
  logic              o_busy;
  logic              o_done;
  logic [1:0]        o_state;

  modport master (
    output i_start, i_op, i_a, i_b, i_mthi, i_mtlo, i_wdata, i_flush,
    input  o_hi, o_lo, o_busy, o_done, o_state
  );

  modport slave (
    input  i_start, i_op, i_a, i_b, i_mthi, i_mtlo, i_wdata, i_flush,
    output o_hi, o_lo, o_busy, o_done, o_state
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers. Each operation
// processes one bit per cycle, takes LENGTH cycles, and then spends one
// cycle on sign fix-up.
module mips_muldiv_unit #(
  parameter int LENGTH = 32,
  localparam int CNT_W = $clog2(LENGTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mips_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LENGTH-1:0]   hi_q, hi_d;
  logic [LENGTH-1:0]   lo_q, lo_d;
  logic [LENGTH-1:0]   m_q, m_d;
  logic [LENGTH-1:0]   a_raw_q, a_raw_d;
  logic [2*LENGTH-1:0] acc_q, acc_d;
  logic                is_div_q, is_div_d;
  logic                neg_q, neg_d;
  logic                sign_a_q, sign_a_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                in_sign_a, in_sign_b;
  logic [LENGTH-1:0]   a_mag, b_mag;
  logic [LENGTH:0]     mul_sum, div_rem, div_diff;
  logic [2*LENGTH-1:0] mul_step, div_step, prod;
  logic [LENGTH-1:0]   quot, rem;

  assign in_sign_a = bus.i_op[0] & bus.i_a[LENGTH-1];
  assign in_sign_b = bus.i_op[0] & bus.i_b[LENGTH-1];
  assign a_mag     = in_sign_a ? -bus.i_a : bus.i_a;
  assign b_mag     = in_sign_b ? -bus.i_b : bus.i_b;

  // m_q holds the operand that is not kept in the accumulator: the
  // multiplicand for a multiply, or the divisor for a divide.
  assign mul_sum  = {1'b0, acc_q[2*LENGTH-1:LENGTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign mul_step = {mul_sum, acc_q[LENGTH-1:1]};

  // Restoring divide: the upper half is the partial remainder and the lower
  // half shifts the dividend out while the quotient shifts in.
  assign div_rem  = {acc_q[2*LENGTH-1:LENGTH], acc_q[LENGTH-1]};
  assign div_diff = div_rem - {1'b0, m_q};
  assign div_step = div_diff[LENGTH]
                  ? {div_rem[LENGTH-1:0], acc_q[LENGTH-2:0], 1'b0}
                  : {div_diff[LENGTH-1:0], acc_q[LENGTH-2:0], 1'b1};

  assign prod = neg_q ? -acc_q : acc_q;
  assign quot = neg_q ? -acc_q[LENGTH-1:0] : acc_q[LENGTH-1:0];
  assign rem  = sign_a_q ? -acc_q[2*LENGTH-1:LENGTH] : acc_q[2*LENGTH-1:LENGTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    a_raw_d  = a_raw_q;
    acc_d    = acc_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    sign_a_d = sign_a_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_start && !bus.i_flush) begin
          is_div_d = bus.i_op[1];
          sign_a_d = in_sign_a;
          neg_d    = in_sign_a ^ in_sign_b;
          a_raw_d  = bus.i_a;
          m_d      = bus.i_op[1] ? b_mag : a_mag;
          acc_d    = {{LENGTH{1'b0}}, (bus.i_op[1] ? a_mag : b_mag)};
          cnt_d    = '0;
          state_d  = CALC;
        end else begin
          if (bus.i_mthi) hi_d = bus.i_wdata;
          if (bus.i_mtlo) lo_d = bus.i_wdata;
        end
      end
      CALC: begin
        if (bus.i_flush) begin
          state_d = IDLE;
        end else begin
          acc_d = is_div_q ? div_step : mul_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LENGTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.i_flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod;
          end else if (m_q == '0) begin
            lo_d = '1;
            hi_d = a_raw_q;
          end else begin
            lo_d = quot;
            hi_d = rem;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      a_raw_q  <= '0;
      acc_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      a_raw_q  <= a_raw_d;
      acc_q    <= acc_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      sign_a_q <= sign_a_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.o_hi    = hi_q;
  assign bus.o_lo    = lo_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;
  assign bus.o_state = state_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit. Expected {HI,LO} values are queued when
// each operation is issued, and a monitor checks them on every o_done pulse.
module tb_mips_muldiv_unit;
  localparam int L = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_muldiv_if #(.LENGTH(L)) bus();

  mips_muldiv_unit #(.LENGTH(L)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int          checks   = 0;
  int          errors   = 0;
  int          done_cnt = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every o_done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.o_done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done actual=%h_%h expected=no_done", bus.o_hi, bus.o_lo);
      end else begin
        check("result_hilo", {bus.o_hi, bus.o_lo}, exp_q.pop_front());
      end
    end
  end

  task automatic drive_idle();
    bus.i_start = 1'b0; bus.i_op = 2'b00; bus.i_a = '0; bus.i_b = '0;
    bus.i_mthi = 1'b0;  bus.i_mtlo = 1'b0; bus.i_wdata = '0; bus.i_flush = 1'b0;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit push, input logic [63:0] exp);
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op = op; bus.i_a = a; bus.i_b = b;
    if (push) exp_q.push_back(exp);
  endtask

  // Counts busy cycles until o_done. Optionally flushes, or pokes a start and
  // an MTHI, at a given cycle of the operation.
  task automatic run_to_done(input int flush_at, input int poke_at,
                             output int busy_n, output bit done_seen);
    busy_n = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bus.i_start = 1'b0; bus.i_mthi = 1'b0; bus.i_flush = 1'b0;
      if (bus.o_busy) busy_n++;
      if (bus.o_done) begin
        done_seen = 1'b1;
        break;
      end
      if (flush_at >= 0 && i > flush_at && !bus.o_busy) break;
      if (i == flush_at) bus.i_flush = 1'b1;
      if (i == poke_at) begin
        bus.i_start = 1'b1; bus.i_op = 2'b11; bus.i_a = 32'd50; bus.i_b = 32'd5;
        bus.i_mthi = 1'b1;  bus.i_wdata = 32'h0000DEAD;
      end
    end
  endtask

  task automatic op_test(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    int busy_n;
    bit done_seen;
    start_op(op, a, b, 1'b1, exp);
    run_to_done(-1, -1, busy_n, done_seen);
    check({name, "_done"}, 64'(done_seen), 64'd1);
    check({name, "_busy_cycles"}, 64'(busy_n), 64'd33);
  endtask

  initial begin
    int  busy_n;
    bit  done_seen;
    int  d0;
    bit  got;

    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hilo", {bus.o_hi, bus.o_lo}, 64'd0);
    check("reset_flags", {bus.o_busy, bus.o_done, bus.o_state}, 64'd0);
    rst_n = 1'b1;

    op_test("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    op_test("mult_neg",  2'b01, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1);
    op_test("div_neg",   2'b11, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD);
    op_test("divu",      2'b10, 32'd100,      32'd7,        64'h00000002_0000000E);
    op_test("divu_zero", 2'b10, 32'd7,        32'd0,        64'h00000007_FFFFFFFF);
    op_test("div_ovf",   2'b11, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);

    // A start and an MTHI issued while busy must both be ignored.
    start_op(2'b00, 32'd6, 32'd7, 1'b1, 64'h00000000_0000002A);
    run_to_done(-1, 5, busy_n, done_seen);
    check("poke_done", 64'(done_seen), 64'd1);
    check("poke_busy_cycles", 64'(busy_n), 64'd33);
    @(negedge clk);
    check("poke_no_restart", 64'(bus.o_busy), 64'd0);

    // MTHI and MTLO preload, then flush an in-flight MULT.
    bus.i_mthi = 1'b1; bus.i_wdata = 32'h0000AAAA;
    @(negedge clk);
    bus.i_mthi = 1'b0; bus.i_mtlo = 1'b1; bus.i_wdata = 32'h00005555;
    @(negedge clk);
    bus.i_mtlo = 1'b0;
    check("mthi_mtlo", {bus.o_hi, bus.o_lo}, 64'h0000AAAA_00005555);
    d0 = done_cnt;
    start_op(2'b01, 32'hFFFFFFFD, 32'd5, 1'b0, 64'd0);
    run_to_done(9, -1, busy_n, done_seen);
    check("flush_busy_cycles", 64'(busy_n), 64'd10);
    check("flush_no_done", 64'(done_seen), 64'd0);
    repeat (40) @(negedge clk);
    check("flush_done_count", 64'(done_cnt), 64'(d0));
    check("flush_hilo_kept", {bus.o_hi, bus.o_lo}, 64'h0000AAAA_00005555);

    // A flush in IDLE blocks the start, but the same-cycle MTHI still lands.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_op = 2'b00; bus.i_a = 32'd2; bus.i_b = 32'd3;
    bus.i_flush = 1'b1; bus.i_mthi = 1'b1; bus.i_wdata = 32'h00000077;
    @(negedge clk);
    drive_idle();
    check("idle_flush_busy", 64'(bus.o_busy), 64'd0);
    check("idle_flush_mthi", {bus.o_hi, bus.o_lo}, 64'h00000077_00005555);
    repeat (40) @(negedge clk);
    check("idle_flush_no_done", 64'(done_cnt), 64'(d0));

    // Back-to-back: a new start is issued in the o_done cycle.
    start_op(2'b10, 32'd100, 32'd7, 1'b1, 64'h00000002_0000000E);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      if (bus.o_done) begin
        bus.i_start = 1'b1; bus.i_op = 2'b00; bus.i_a = 32'd3; bus.i_b = 32'd4;
        exp_q.push_back(64'h00000000_0000000C);
        got = 1'b1;
        break;
      end
    end
    check("b2b_first_done", 64'(got), 64'd1);
    @(negedge clk);
    bus.i_start = 1'b0;
    check("b2b_busy_again", 64'(bus.o_busy), 64'd1);
    run_to_done(-1, -1, busy_n, done_seen);
    check("b2b_second_done", 64'(done_seen), 64'd1);
    check("b2b_busy_cycles", 64'(busy_n), 64'd32);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    bus.i_mthi = 1'b1; bus.i_wdata = 32'h0000BEEF;
    @(negedge clk);
    bus.i_mthi = 1'b0;
    start_op(2'b00, 32'd9, 32'd9, 1'b0, 64'd0);
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_busy", 64'(bus.o_busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_hilo", {bus.o_hi, bus.o_lo}, 64'd0);
    check("async_reset_flags", {bus.o_busy, bus.o_done, bus.o_state}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.i_mthi = 1'b1; bus.i_wdata = 32'h00001234;
    @(negedge clk);
    bus.i_mthi = 1'b0;
    check("post_reset_mthi", {bus.o_hi, bus.o_lo}, 64'h00001234_00000000);
    repeat (40) @(negedge clk);
    check("post_reset_idle", 64'(bus.o_busy), 64'd0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
